// File: rtl/num_decoder7_if.sv
// Signal bundle between a digit source and the num_decoder7 segment driver.
// The source (master) drives the latch/blank/lamp-test controls and the digit
// code; the decoder (slave) returns the registered segment lines.
interface num_decoder7_if;
  logic       LE;
  logic       BL;
  logic       LT;
  logic [3:0] D;
  logic [6:0] L;

  modport master (
    output LE,
    output BL,
    output LT,
    output D,
    input  L
  );

  modport slave (
    input  LE,
    input  BL,
    input  LT,
    input  D,
    output L
  );
endinterface

// File: rtl/num_decoder7.sv
// BCD/hex to 7-segment decoder/driver modelled on the CD4511.
// A clocked input latch holds the digit while LE=1. While LE=0 the incoming
// code is decoded directly, so there is no extra cycle of delay. Lamp test
// overrides blanking, blanking overrides decode, and the result is registered
// so the segment lines never glitch. Segment order is L[6]=a .. L[0]=g.
module num_decoder7 #(
  parameter bit HEX_MODE    = 1'b0,
  parameter bit SEG_ACT_LOW = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  num_decoder7_if.slave  bus
);

  // Value the output register takes during reset: all segments dark.
  localparam logic [6:0] BLANK_OUT = SEG_ACT_LOW ? 7'h7F : 7'h00;

  logic [3:0] d_q;
  logic [3:0] d_d;
  logic [3:0] sel;
  logic [6:0] seg_dec;
  logic [6:0] seg_pri;
  logic [6:0] l_d;
  logic [6:0] l_q;

  // Latch next-state and the code actually being decoded this cycle.
  always_comb begin
    d_d = bus.LE ? d_q : bus.D;
    sel = bus.LE ? d_q : bus.D;
  end

  // Decode table; codes above 9 are letters only when HEX_MODE is set.
  always_comb begin
    seg_dec = 7'h00;
    unique case (sel)
      4'd0:  seg_dec = 7'h7E;
      4'd1:  seg_dec = 7'h30;
      4'd2:  seg_dec = 7'h6D;
      4'd3:  seg_dec = 7'h79;
      4'd4:  seg_dec = 7'h33;
      4'd5:  seg_dec = 7'h5B;
      4'd6:  seg_dec = 7'h5F;
      4'd7:  seg_dec = 7'h70;
      4'd8:  seg_dec = 7'h7F;
      4'd9:  seg_dec = 7'h7B;
      4'd10: seg_dec = HEX_MODE ? 7'h77 : 7'h00;
      4'd11: seg_dec = HEX_MODE ? 7'h1F : 7'h00;
      4'd12: seg_dec = HEX_MODE ? 7'h4E : 7'h00;
      4'd13: seg_dec = HEX_MODE ? 7'h3D : 7'h00;
      4'd14: seg_dec = HEX_MODE ? 7'h4F : 7'h00;
      4'd15: seg_dec = HEX_MODE ? 7'h47 : 7'h00;
      default: seg_dec = 7'h00;
    endcase
  end

  // Lamp test beats blanking beats decode; polarity is applied last.
  always_comb begin
    seg_pri = seg_dec;
    if (!bus.LT) begin
      seg_pri = 7'h7F;
    end else if (!bus.BL) begin
      seg_pri = 7'h00;
    end
    l_d = SEG_ACT_LOW ? ~seg_pri : seg_pri;
  end

  // Input latch and output register; reset clears the digit and darkens the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 4'h0;
      l_q <= BLANK_OUT;
    end else begin
      d_q <= d_d;
      l_q <= l_d;
    end
  end

  assign bus.L = l_q;

endmodule

// File: tb/tb_num_decoder7.sv
// Testbench for num_decoder7: three instances (decimal/active-high,
// hex/active-high, decimal/active-low) share the same stimulus.
module tb_num_decoder7;

  logic clk;
  logic rst_n;

  num_decoder7_if busDec ();
  num_decoder7_if busHex ();
  num_decoder7_if busLow ();

  num_decoder7 #(.HEX_MODE(1'b0), .SEG_ACT_LOW(1'b0)) dutDec (
    .clk(clk), .rst_n(rst_n), .bus(busDec.slave));
  num_decoder7 #(.HEX_MODE(1'b1), .SEG_ACT_LOW(1'b0)) dutHex (
    .clk(clk), .rst_n(rst_n), .bus(busHex.slave));
  num_decoder7 #(.HEX_MODE(1'b0), .SEG_ACT_LOW(1'b1)) dutLow (
    .clk(clk), .rst_n(rst_n), .bus(busLow.slave));

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       le;
    logic       bl;
    logic       lt;
    logic [3:0] d;
    logic [6:0] expDec;
    logic [6:0] expHex;
  } vec_t;

  vec_t vecs[$];
  int   compared;
  int   mismatched;

  // Independent reference of the segment table for the random phase.
  function automatic logic [6:0] refDecode(input logic hex, input logic [3:0] d);
    case (d)
      4'd0: refDecode = 7'h7E;  4'd1: refDecode = 7'h30;
      4'd2: refDecode = 7'h6D;  4'd3: refDecode = 7'h79;
      4'd4: refDecode = 7'h33;  4'd5: refDecode = 7'h5B;
      4'd6: refDecode = 7'h5F;  4'd7: refDecode = 7'h70;
      4'd8: refDecode = 7'h7F;  4'd9: refDecode = 7'h7B;
      4'd10: refDecode = hex ? 7'h77 : 7'h00;
      4'd11: refDecode = hex ? 7'h1F : 7'h00;
      4'd12: refDecode = hex ? 7'h4E : 7'h00;
      4'd13: refDecode = hex ? 7'h3D : 7'h00;
      4'd14: refDecode = hex ? 7'h4F : 7'h00;
      default: refDecode = hex ? 7'h47 : 7'h00;
    endcase
  endfunction

  // Drive identical inputs to all three instances.
  task automatic applyStimulus(input logic le, input logic bl, input logic lt,
                               input logic [3:0] d);
    busDec.LE = le; busDec.BL = bl; busDec.LT = lt; busDec.D = d;
    busHex.LE = le; busHex.BL = bl; busHex.LT = lt; busHex.D = d;
    busLow.LE = le; busLow.BL = bl; busLow.LT = lt; busLow.D = d;
  endtask

  // Compare all three outputs; the active-low instance must show the inverse of the decimal value.
  task automatic checkOutput(input string name, input logic [6:0] expDec,
                             input logic [6:0] expHex);
    logic [6:0] expLow;
    expLow = ~expDec;
    compared++;
    if (busDec.L !== expDec) begin
      mismatched++;
      $display("[TB] FAIL %s dec: got %h expected %h", name, busDec.L, expDec);
    end
    compared++;
    if (busHex.L !== expHex) begin
      mismatched++;
      $display("[TB] FAIL %s hex: got %h expected %h", name, busHex.L, expHex);
    end
    compared++;
    if (busLow.L !== expLow) begin
      mismatched++;
      $display("[TB] FAIL %s actlow: got %h expected %h", name, busLow.L, expLow);
    end
  endtask

  task automatic addVec(input logic le, input logic bl, input logic lt,
                        input logic [3:0] d, input logic [6:0] eDec,
                        input logic [6:0] eHex);
    vec_t v;
    v.le = le; v.bl = bl; v.lt = lt; v.d = d; v.expDec = eDec; v.expHex = eHex;
    vecs.push_back(v);
  endtask

  // Apply inputs on the falling edge, sample 1 ns after the next rising edge.
  task automatic stepAndCheck(input string name, input logic le, input logic bl,
                              input logic lt, input logic [3:0] d,
                              input logic [6:0] eDec, input logic [6:0] eHex);
    @(negedge clk);
    applyStimulus(le, bl, lt, d);
    @(posedge clk);
    #1;
    checkOutput(name, eDec, eHex);
  endtask

  initial begin
    logic [3:0] rd;
    compared   = 0;
    mismatched = 0;

    // Sweep 0..15 (LE=0, BL=1, LT=1)
    addVec(0,1,1,4'd0, 7'h7E,7'h7E); addVec(0,1,1,4'd1, 7'h30,7'h30);
    addVec(0,1,1,4'd2, 7'h6D,7'h6D); addVec(0,1,1,4'd3, 7'h79,7'h79);
    addVec(0,1,1,4'd4, 7'h33,7'h33); addVec(0,1,1,4'd5, 7'h5B,7'h5B);
    addVec(0,1,1,4'd6, 7'h5F,7'h5F); addVec(0,1,1,4'd7, 7'h70,7'h70);
    addVec(0,1,1,4'd8, 7'h7F,7'h7F); addVec(0,1,1,4'd9, 7'h7B,7'h7B);
    addVec(0,1,1,4'd10,7'h00,7'h77); addVec(0,1,1,4'd11,7'h00,7'h1F);
    addVec(0,1,1,4'd12,7'h00,7'h4E); addVec(0,1,1,4'd13,7'h00,7'h3D);
    addVec(0,1,1,4'd14,7'h00,7'h4F); addVec(0,1,1,4'd15,7'h00,7'h47);
    // Latch: capture 5, hold through D changes, reopen on 2
    addVec(0,1,1,4'd5, 7'h5B,7'h5B); addVec(1,1,1,4'd2, 7'h5B,7'h5B);
    addVec(1,1,1,4'd7, 7'h5B,7'h5B); addVec(0,1,1,4'd2, 7'h6D,7'h6D);
    // Priority: LT over BL, then BL, then decode
    addVec(0,0,0,4'd1, 7'h7F,7'h7F); addVec(0,0,1,4'd1, 7'h00,7'h00);
    addVec(0,1,1,4'd1, 7'h30,7'h30);
    // Held digit survives lamp test and blanking
    addVec(0,1,1,4'd9, 7'h7B,7'h7B); addVec(1,1,0,4'd3, 7'h7F,7'h7F);
    addVec(1,0,1,4'd3, 7'h00,7'h00); addVec(1,1,1,4'd12,7'h7B,7'h7B);

    // Reset phase: create a clean falling edge on rst_n
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset", 7'h00, 7'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release", 7'h7E, 7'h7E);

    foreach (vecs[i]) begin
      stepAndCheck($sformatf("vec%0d", i), vecs[i].le, vecs[i].bl, vecs[i].lt,
                   vecs[i].d, vecs[i].expDec, vecs[i].expHex);
    end

    // Mid-operation reset: blank at once, stays blank across an edge, digit cleared
    stepAndCheck("preRst", 1'b0, 1'b1, 1'b1, 4'd8, 7'h7F, 7'h7F);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstNow", 7'h00, 7'h00);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd6);
    @(posedge clk);
    #1;
    checkOutput("midRstHeld", 7'h00, 7'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstLatchClr", 7'h7E, 7'h7E);
    stepAndCheck("postRst", 1'b0, 1'b1, 1'b1, 4'd4, 7'h33, 7'h33);

    // Random digits, reference table with one-cycle delay
    for (int k = 0; k < 40; k++) begin
      rd = 4'($urandom_range(0, 15));
      stepAndCheck($sformatf("rand%0d_d%0d", k, rd), 1'b0, 1'b1, 1'b1, rd,
                   refDecode(1'b0, rd), refDecode(1'b1, rd));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
